// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage state encoding and default PC increment.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, SQUASH} fetch_state_t;
    localparam int DEFAULT_PC_STEP = 4;
endpackage

// File: rtl/fetch_hold_reg.sv
// fetch_hold_reg: enable-loaded holding copy of the fetched instruction and its incremented PC.
// Ports: clk, reset (sync, active-high clear), load (capture enable),
//        inst/pc_inc (values to capture), hold_inst/hold_pc_inc (held values).
module fetch_hold_reg #(
    parameter int DATA_BIT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [DATA_BIT_WIDTH-1:0] inst,
    input  logic [DATA_BIT_WIDTH-1:0] pc_inc,
    output logic [DATA_BIT_WIDTH-1:0] hold_inst,
    output logic [DATA_BIT_WIDTH-1:0] hold_pc_inc
);
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_inst   <= '0;
            hold_pc_inc <= '0;
        end else if (load) begin
            hold_inst   <= inst;
            hold_pc_inc <= pc_inc;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the PC and a variable-latency imem req/ack port.
// Ports: clk, reset (sync, active-high); stall, redirect, redirectTarget from the pipeline;
//        imemReq/imemAddr out and imemAck/imemData in for instruction memory;
//        instValid/pcIncrementedOut/instOut toward the IF/ID latch (zeros when invalid).
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                        DATA_BIT_WIDTH = 32,
    parameter logic [DATA_BIT_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                        PC_STEP        = DEFAULT_PC_STEP
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [DATA_BIT_WIDTH-1:0] redirectTarget,
    output logic                      imemReq,
    output logic [DATA_BIT_WIDTH-1:0] imemAddr,
    input  logic                      imemAck,
    input  logic [DATA_BIT_WIDTH-1:0] imemData,
    output logic                      instValid,
    output logic [DATA_BIT_WIDTH-1:0] pcIncrementedOut,
    output logic [DATA_BIT_WIDTH-1:0] instOut
);
    localparam logic [DATA_BIT_WIDTH-1:0] STEP = DATA_BIT_WIDTH'(PC_STEP);

    fetch_state_t              state;
    logic [DATA_BIT_WIDTH-1:0] pc;
    logic [DATA_BIT_WIDTH-1:0] req_addr;
    logic [DATA_BIT_WIDTH-1:0] req_next;
    logic [DATA_BIT_WIDTH-1:0] hold_inst;
    logic [DATA_BIT_WIDTH-1:0] hold_pc_inc;
    logic                      fetch_ok;
    logic                      in_hold;

    assign req_next = req_addr + STEP;
    assign in_hold  = state == HOLD;
    // A live fetch completes only on an unsquashed ack while requesting.
    assign fetch_ok = state == FETCH && imemAck && !redirect;

    fetch_hold_reg #(.DATA_BIT_WIDTH(DATA_BIT_WIDTH)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (fetch_ok && stall),
        .inst       (imemData),
        .pc_inc     (req_next),
        .hold_inst  (hold_inst),
        .hold_pc_inc(hold_pc_inc)
    );

    always_comb begin
        imemReq          = !in_hold;
        imemAddr         = req_addr;
        instValid        = fetch_ok || (in_hold && !redirect);
        instOut          = !instValid ? '0 : in_hold ? hold_inst : imemData;
        pcIncrementedOut = !instValid ? '0 : in_hold ? hold_pc_inc : req_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_VALUE;
            req_addr <= RESET_VALUE;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc <= redirectTarget;
                        if (imemAck) req_addr <= redirectTarget;
                        else state <= SQUASH;
                    end else if (imemAck) begin
                        if (stall) begin
                            state <= HOLD;
                        end else begin
                            pc       <= req_next;
                            req_addr <= req_next;
                        end
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        pc       <= redirect ? redirectTarget : req_next;
                        req_addr <= redirect ? redirectTarget : req_next;
                        state    <= FETCH;
                    end
                end
                default: begin
                    // A redirect landing on the drain ack must still win over the older target.
                    if (redirect) pc <= redirectTarget;
                    if (imemAck) begin
                        req_addr <= redirect ? redirectTarget : pc;
                        state    <= FETCH;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, imem_ack;
    logic [31:0] redirect_target, imem_data;
    logic        req, valid, w_req, w_valid;
    logic [31:0] addr, pc_inc, inst, w_addr, w_pc_inc, w_inst;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign imem_data = addr ^ MAGIC;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirectTarget(redirect_target), .imemReq(req), .imemAddr(addr),
        .imemAck(imem_ack), .imemData(imem_data), .instValid(valid),
        .pcIncrementedOut(pc_inc), .instOut(inst)
    );

    if_fetch_unit #(.RESET_VALUE(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirectTarget(redirect_target), .imemReq(w_req), .imemAddr(w_addr),
        .imemAck(imem_ack), .imemData(imem_data), .instValid(w_valid),
        .pcIncrementedOut(w_pc_inc), .instOut(w_inst)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic a, input logic [31:0] t);
        stall = s;
        redirect = r;
        imem_ack = a;
        redirect_target = t;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0);
        tests++;
        if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0 || inst !== 32'h0 || pc_inc !== 32'h0) begin
            fails++;
            $display("FAIL reset: req=%b addr=%h valid=%b inst=%h pcinc=%h, want 1 0 0 0 0", req, addr, valid, inst, pc_inc);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            tests++;
            if (valid !== 1'b1 || pc_inc !== 32'(4 * (i + 1)) || inst !== (32'(4 * i) ^ MAGIC)) begin
                fails++;
                $display("FAIL zero_wait[%0d]: valid=%b pcinc=%h inst=%h, want 1 %h %h", i, valid, pc_inc, inst, 32'(4 * (i + 1)), 32'(4 * i) ^ MAGIC);
            end
            step();
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            tests++;
            if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin
                fails++;
                $display("FAIL latency_wait[%0d]: req=%b addr=%h valid=%b, want 1 0 0", i, req, addr, valid);
            end
            step();
        end
        drive(0, 0, 1, 0);
        tests++;
        if (valid !== 1'b1 || inst !== MAGIC || pc_inc !== 32'h4) begin
            fails++;
            $display("FAIL latency_ack: valid=%b inst=%h pcinc=%h, want 1 %h 4", valid, inst, pc_inc, MAGIC);
        end
        step();
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 1, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 0, i == 0, 0);
            tests++;
            if (valid !== 1'b1 || pc_inc !== 32'd12 || inst !== (32'd8 ^ MAGIC) || (i > 0 && req !== 1'b0)) begin
                fails++;
                $display("FAIL stall_hold[%0d]: valid=%b pcinc=%h inst=%h req=%b, want 1 c %h req0", i, valid, pc_inc, inst, req, 32'd8 ^ MAGIC);
            end
            step();
        end
        drive(0, 0, 0, 0);
        tests++;
        if (req !== 1'b1 || addr !== 32'd12 || valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: req=%b addr=%h valid=%b, want 1 c 0", req, addr, valid);
        end
    endtask

    task automatic test_squash();
        do_reset();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 1, 0); step();
        drive(0, 1, 0, 32'h100);
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL squash_redirect: valid=%b, want 0", valid);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, i == 1, 0);
            tests++;
            if (req !== 1'b1 || addr !== 32'h8 || valid !== 1'b0) begin
                fails++;
                $display("FAIL squash_drain[%0d]: req=%b addr=%h valid=%b, want 1 8 0", i, req, addr, valid);
            end
            step();
        end
        drive(0, 0, 0, 0);
        tests++;
        if (req !== 1'b1 || addr !== 32'h100) begin
            fails++;
            $display("FAIL squash_target: req=%b addr=%h, want 1 100", req, addr);
        end
        drive(0, 1, 0, 32'h200); step();
        drive(0, 1, 0, 32'h300); step();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 0, 0);
        tests++;
        if (addr !== 32'h300) begin
            fails++;
            $display("FAIL squash_last_wins: addr=%h, want 300", addr);
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        drive(0, 1, 1, 32'h40);
        tests++;
        if (valid !== 1'b0 || inst !== 32'h0 || pc_inc !== 32'h0) begin
            fails++;
            $display("FAIL redir_ack: valid=%b inst=%h pcinc=%h, want 0 0 0", valid, inst, pc_inc);
        end
        step();
        drive(1, 0, 1, 0);
        tests++;
        if (addr !== 32'h40 || valid !== 1'b1) begin
            fails++;
            $display("FAIL redir_ack_next: addr=%h valid=%b, want 40 1", addr, valid);
        end
        step();
        drive(1, 1, 0, 32'h80);
        tests++;
        if (valid !== 1'b0 || req !== 1'b0) begin
            fails++;
            $display("FAIL redir_hold: valid=%b req=%b, want 0 0", valid, req);
        end
        step();
        drive(0, 0, 0, 0);
        tests++;
        if (addr !== 32'h80 || req !== 1'b1) begin
            fails++;
            $display("FAIL redir_hold_next: addr=%h req=%b, want 80 1", addr, req);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(0, 0, 1, 0);
        tests++;
        if (w_addr !== 32'hFFFF_FFFC || w_valid !== 1'b1 || w_pc_inc !== 32'h0) begin
            fails++;
            $display("FAIL wrap: addr=%h valid=%b pcinc=%h, want fffffffc 1 0", w_addr, w_valid, w_pc_inc);
        end
        step();
        drive(0, 0, 0, 0);
        tests++;
        if (w_addr !== 32'h0 || w_req !== 1'b1 || w_inst !== 32'h0) begin
            fails++;
            $display("FAIL wrap_next: addr=%h req=%b inst=%h, want 0 1 0", w_addr, w_req, w_inst);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 1, 0); step();
        drive(0, 0, 0, 0); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        tests++;
        if (addr !== 32'h0 || valid !== 1'b0 || req !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: addr=%h valid=%b req=%b, want 0 0 1", addr, valid, req);
        end
    endtask

    // Reference: bus address, pending post-drain target, and whether an instruction is parked.
    task automatic test_random();
        logic [31:0] cur, nxt, h_inst, h_inc, e_inst, e_inc, tgt;
        logic        holding, draining, s, r, a, e_valid;
        cur = 0; nxt = 0; h_inst = 0; h_inc = 0;
        holding = 0; draining = 0;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            s = $urandom_range(0, 9) < 3;
            r = $urandom_range(0, 9) < 2;
            a = $urandom_range(0, 1) == 1;
            tgt = {$urandom_range(0, 32'h3FFF), 2'b00};
            drive(s, r, a, tgt);
            e_valid = !r && (holding || (!draining && a));
            e_inst = !e_valid ? 0 : holding ? h_inst : cur ^ MAGIC;
            e_inc = !e_valid ? 0 : holding ? h_inc : cur + 4;
            tests++;
            if (req !== !holding || addr !== cur || valid !== e_valid || inst !== e_inst || pc_inc !== e_inc) begin
                fails++;
                $display("FAIL random[%0d]: req=%b addr=%h valid=%b inst=%h pcinc=%h, want %b %h %b %h %h",
                         i, req, addr, valid, inst, pc_inc, !holding, cur, e_valid, e_inst, e_inc);
            end
            if (holding) begin
                if (r) begin cur = tgt; holding = 0; end
                else if (!s) begin cur = cur + 4; holding = 0; end
            end else if (draining) begin
                if (r) nxt = tgt;
                if (a) begin cur = nxt; draining = 0; end
            end else if (r) begin
                if (a) cur = tgt;
                else begin nxt = tgt; draining = 1; end
            end else if (a) begin
                if (s) begin holding = 1; h_inst = cur ^ MAGIC; h_inc = cur + 4; end
                else cur = cur + 4;
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        step();
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_squash();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that produces the incremented PC and instruction consumed by the IF/ID pipeline latch. Owns the PC register and drives a variable-latency instruction-memory request/acknowledge interface. Honours stall from the hazard unit and redirect (taken branch/jump) from EX. Reports invalid cycles so the integrator can drive a bubble into the latch.

## Interface
- DATA_BIT_WIDTH, 32, width of PC, addresses, instruction words
- RESET_VALUE, 0, PC after reset
- PC_STEP, 4, PC increment per instruction
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state at the clk edge where it is high
- stall  in  1  IF/ID latch is holding; the presented instruction must not advance
- redirect  in  1  taken branch/jump this cycle; squash the current fetch
- redirectTarget  in  DATA_BIT_WIDTH  new PC when redirect=1
- imemReq  out  1  instruction-memory request
- imemAddr  out  DATA_BIT_WIDTH  request address; stable while imemReq=1 and no ack
- imemAck  in  1  single-cycle acknowledge; imemData valid in the same cycle
- imemData  in  DATA_BIT_WIDTH  returned instruction
- instValid  out  1  pcIncrementedOut/instOut are a real instruction this cycle
- pcIncrementedOut  out  DATA_BIT_WIDTH  fetched address + PC_STEP; 0 when instValid=0
- instOut  out  DATA_BIT_WIDTH  fetched instruction; 0 when instValid=0

## Operation
- States: FETCH (request outstanding at pc), HOLD (instruction captured, waiting for stall to drop), SQUASH (draining an abandoned request).
- Registers: pc, reqAddr, holdInst, holdPcInc, state.
- Memory protocol: once raised, imemReq stays high with the same imemAddr until imemAck. imemAck with imemReq=0 is ignored. Zero-wait ack is legal.
- imemReq is 1 in FETCH and SQUASH and 0 in HOLD. imemAddr equals reqAddr.
- FETCH, ack=1, redirect=0:
  - instValid=1, instOut=imemData, pcIncrementedOut=reqAddr+PC_STEP.
  - If stall=0: pc and reqAddr advance to reqAddr+PC_STEP; stay in FETCH.
  - If stall=1: capture the instruction into the hold registers; go to HOLD.
- FETCH, ack=0, redirect=0: instValid=0; hold all state.
- HOLD: instValid=1 from the hold registers. When stall=0, advance pc and reqAddr by PC_STEP and go to FETCH.
- Redirect has priority over stall and ack in every state. instValid=0 in any redirect cycle.
  - FETCH with ack: pc and reqAddr take redirectTarget; stay in FETCH.
  - FETCH without ack: pc takes redirectTarget and reqAddr is unchanged; go to SQUASH.
  - HOLD: pc and reqAddr take redirectTarget; go to FETCH.
  - SQUASH: pc takes redirectTarget (the newest redirect wins).
- SQUASH: instValid=0. imemData is discarded. On ack, reqAddr takes pc; go to FETCH.
- Integration: latch flush = redirect | ~instValid; latch stall = stall.
- Arithmetic: PC additions are modulo 2^DATA_BIT_WIDTH, so the PC wraps silently. Target alignment is not checked.

## Timing
- Reset values: state=FETCH, pc=reqAddr=RESET_VALUE, holdInst=holdPcInc=0.
- Outputs in the cycle after the reset edge: imemReq=1, imemAddr=RESET_VALUE, instValid=0, instOut=0, pcIncrementedOut=0.
- Latency: the instruction is presented combinationally in the ack cycle. With zero-wait memory and stall=0, the unit sustains one instruction per cycle.
- Redirect-to-target: a redirect in FETCH with ack puts the target on imemAddr the next cycle. A redirect in FETCH without ack delays the target until one cycle after the drain ack.
- Simultaneous events:
  - stall and redirect together: redirect wins.
  - ack and redirect together: the data is dropped.
  - Back-to-back redirects in SQUASH: the last target wins.
- Reset mid-transaction: the outstanding request is abandoned with no drain. The memory must share the same reset.

## Structure
- Shared package fetch_pkg: state enum (FETCH, HOLD, SQUASH), default PC_STEP constant.
- One natural sub-module: fetch_hold_reg, the enable-loaded holdInst/holdPcInc pair with synchronous clear.

## Test plan
- Reset then zero-wait memory returning addr^32'hA5A5_0000, stall=0 → consecutive cycles present pcIncrementedOut 4, 8, 12 with instValid=1 every cycle.
- Memory with 3-cycle latency → imemAddr held at 0 for 3 cycles, instValid=0 until ack; instruction at 0 presented in the ack cycle with pcIncrementedOut=4.
- Stall high for 2 cycles at ack of addr 8 → HOLD, instOut/pcIncrementedOut=12 stable for 2 cycles with imemReq=0; next fetch addr 12 issued after stall drops.
- Redirect to 0x100 while the request at 8 is outstanding (ack 2 cycles later) → SQUASH, imemAddr stays 8, data at 8 never valid; next request at 0x100.
- Redirect to 0x40 coinciding with ack, and a separate case with stall=1 in HOLD → instValid=0 that cycle, next imemAddr=0x40.
- Wrap: RESET_VALUE=32'hFFFF_FFFC → pcIncrementedOut=0 and next imemAddr=0. Reset asserted during a pending request → next cycle imemAddr=RESET_VALUE, instValid=0.
